// File: rtl/dev_row_gatherer.sv
// Packs narrow words into one SpatPar-word wide beat; flush emits a zero-padded partial row.
// Latency: 1 cycle from the last accepted word (or flush) to a_valid_o when the output register is free.
// Backpressure: a completed or flushed row waits in the fill buffer while a_ready_i is low; in_ready_o drops meanwhile.
module dev_row_gatherer #(
    parameter int SpatPar   = 8,
    parameter int DataWidth = 64,
    localparam int CntW     = $clog2(SpatPar) + 1,
    localparam int RowW     = SpatPar * DataWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DataWidth-1:0] in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 flush_i,
    output logic [RowW-1:0]      a_o,
    output logic                 a_valid_o,
    input  logic                 a_ready_i,
    output logic [CntW-1:0]      fill_cnt_o,
    output logic [15:0]          beat_cnt_o
);

    logic [RowW-1:0] fill_buf;
    logic [RowW-1:0] row_nxt;
    logic [RowW-1:0] a_q;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_inc;
    logic            fill_full;
    logic            flush_pend;
    logic            a_vld_q;
    logic [15:0]     beat_q;

    logic out_free;
    logic acc;
    logic last_word;
    logic flush_new;
    logic row_done;
    logic xfer;

    // Handshake terms, row assembly and transfer decision.
    always_comb begin
        out_free   = !a_vld_q || a_ready_i;
        in_ready_o = !fill_full && !flush_pend;
        acc        = in_valid_i && in_ready_o;
        last_word  = acc && (cnt == CntW'(SpatPar - 1));
        cnt_inc    = cnt + {{(CntW-1){1'b0}}, acc};
        // A word landing with the flush joins the row first; a flush on an
        // already-full row or an empty row has nothing left to do.
        flush_new  = flush_i && !fill_full && !flush_pend && !last_word &&
                     (cnt_inc != '0);
        row_done   = fill_full || flush_pend || last_word || flush_new;
        xfer       = row_done && out_free;

        // Slots not yet written stay zero because the buffer is cleared on every transfer.
        row_nxt = fill_buf;
        for (int k = 0; k < SpatPar; k++) begin
            if (acc && (cnt == CntW'(k))) begin
                row_nxt[k*DataWidth +: DataWidth] = in_data_i;
            end
        end
    end

    // Fill buffer, row state and output register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fill_buf   <= '0;
            cnt        <= '0;
            fill_full  <= 1'b0;
            flush_pend <= 1'b0;
            a_q        <= '0;
            a_vld_q    <= 1'b0;
        end else if (xfer) begin
            a_q        <= row_nxt;
            a_vld_q    <= 1'b1;
            fill_buf   <= '0;
            cnt        <= '0;
            fill_full  <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            if (a_vld_q && a_ready_i) begin
                a_vld_q <= 1'b0;
            end
            fill_buf <= row_nxt;
            cnt      <= cnt_inc;
            if (last_word) begin
                fill_full <= 1'b1;
            end
            if (flush_new) begin
                flush_pend <= 1'b1;
            end
        end
    end

    // Count of consumed wide beats, wrapping at 16 bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q <= '0;
        end else if (a_vld_q && a_ready_i) begin
            beat_q <= beat_q + 16'd1;
        end
    end

    assign a_o        = a_q;
    assign a_valid_o  = a_vld_q;
    assign fill_cnt_o = cnt;
    assign beat_cnt_o = beat_q;

endmodule

// File: tb/tb_dev_row_gatherer.sv
// Directed bench for dev_row_gatherer with hand-computed expected rows.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled in the same window.
// Backpressure is exercised by holding a_ready low across full and flushed rows.
module tb_dev_row_gatherer;

    localparam int SP = 8;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          flush = 1'b0;
    logic [SP*DW-1:0] a_dat;
    logic          a_vld;
    logic          a_rdy = 1'b0;
    logic [3:0]    fill_cnt;
    logic [15:0]   beat_cnt;

    int n_vec = 0;
    int n_bad = 0;

    dev_row_gatherer #(.SpatPar(SP), .DataWidth(DW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .flush_i    (flush),
        .a_o        (a_dat),
        .a_valid_o  (a_vld),
        .a_ready_i  (a_rdy),
        .fill_cnt_o (fill_cnt),
        .beat_cnt_o (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [SP*DW-1:0] obs, input logic [SP*DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word, optionally with a flush in the same cycle; the block must be ready for it.
    task automatic put(input logic [DW-1:0] d, input logic fl);
        chk("in_ready_before_word", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    // Row whose word k is base+k for k<n, zero above.
    function automatic logic [SP*DW-1:0] seq_row(input logic [DW-1:0] base, input int n);
        logic [SP*DW-1:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[k*DW +: DW] = base + DW'(k);
        return r;
    endfunction

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_a_valid", a_vld, 0);
        chk("rst_a_data", a_dat, 0);
        chk("rst_fill_cnt", fill_cnt, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        rst = 1'b0;
        tick();
        chk("rst_in_ready", in_ready, 1);

        // Full row back-to-back, output always ready
        a_rdy = 1'b1;
        for (int i = 0; i < SP; i++) begin
            chk("row1_no_early_valid", a_vld, 0);
            put(DW'(i + 1), 1'b0);
        end
        chk("row1_valid", a_vld, 1);
        chk("row1_data", a_dat, seq_row(1, 8));
        chk("row1_fill_cnt", fill_cnt, 0);
        tick();
        chk("row1_beat_cnt", beat_cnt, 1);
        chk("row1_valid_drop", a_vld, 0);

        // 16 words against a stalled output
        a_rdy = 1'b0;
        for (int i = 0; i < 2*SP; i++) put(DW'(12'h101 + i), 1'b0);
        chk("stall_valid", a_vld, 1);
        chk("stall_data", a_dat, seq_row(64'h101, 8));
        chk("stall_in_ready", in_ready, 0);
        chk("stall_fill_cnt", fill_cnt, 8);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_data", a_dat, seq_row(64'h101, 8));
            chk("stall_hold_valid", a_vld, 1);
            chk("stall_hold_fill_cnt", fill_cnt, 8);
        end
        a_rdy = 1'b1;
        tick();
        chk("stall_beat2_valid", a_vld, 1);
        chk("stall_beat2_data", a_dat, seq_row(64'h109, 8));
        chk("stall_beat2_cnt", beat_cnt, 2);
        chk("stall_fill_clear", fill_cnt, 0);
        chk("stall_in_ready_back", in_ready, 1);
        tick();
        chk("stall_beat3_cnt", beat_cnt, 3);
        chk("stall_drain_valid", a_vld, 0);

        // Three words then a lone flush
        put(64'hA, 1'b0);
        put(64'hB, 1'b0);
        put(64'hC, 1'b0);
        chk("flush3_fill_cnt", fill_cnt, 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush3_valid", a_vld, 1);
        chk("flush3_data", a_dat, seq_row(64'hA, 3));
        chk("flush3_fill_cnt_clear", fill_cnt, 0);
        tick();
        chk("flush3_beat_cnt", beat_cnt, 4);

        // Flush coinciding with the fifth word
        for (int i = 0; i < 4; i++) put(DW'(8'h21 + i), 1'b0);
        put(64'h25, 1'b1);
        chk("flush5_valid", a_vld, 1);
        chk("flush5_data", a_dat, seq_row(64'h21, 5));
        chk("flush5_fill_cnt", fill_cnt, 0);
        tick();
        chk("flush5_beat_cnt", beat_cnt, 5);

        // Flush held pending behind a stalled output
        a_rdy = 1'b0;
        for (int i = 0; i < SP; i++) put(DW'(8'h41 + i), 1'b0);
        put(64'h51, 1'b0);
        put(64'h52, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("pend_in_ready", in_ready, 0);
        chk("pend_fill_cnt", fill_cnt, 2);
        chk("pend_hold_data", a_dat, seq_row(64'h41, 8));
        tick();
        chk("pend_still_blocked", in_ready, 0);
        a_rdy = 1'b1;
        tick();
        chk("pend_xfer_valid", a_vld, 1);
        chk("pend_xfer_data", a_dat, seq_row(64'h51, 2));
        chk("pend_xfer_fill_cnt", fill_cnt, 0);
        chk("pend_xfer_in_ready", in_ready, 1);
        chk("pend_beat_cnt", beat_cnt, 6);
        tick();
        chk("pend_beat_cnt2", beat_cnt, 7);

        // Flush on an empty row does nothing
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("noop_flush_valid", a_vld, 0);
        tick();
        chk("noop_flush_valid2", a_vld, 0);
        chk("noop_flush_beat_cnt", beat_cnt, 7);

        // Reset mid-row discards the partial row
        for (int i = 0; i < 4; i++) put(DW'(8'h71 + i), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", a_vld, 0);
        chk("midrst_fill_cnt", fill_cnt, 0);
        chk("midrst_beat_cnt", beat_cnt, 0);
        chk("midrst_in_ready", in_ready, 1);
        tick();
        chk("midrst_no_beat", a_vld, 0);
        for (int i = 0; i < SP; i++) put(DW'(8'h61 + i), 1'b0);
        chk("midrst_clean_valid", a_vld, 1);
        chk("midrst_clean_data", a_dat, seq_row(64'h61, 8));
        tick();
        chk("midrst_clean_beat_cnt", beat_cnt, 1);

        // One single-word flushed beat per cycle up to the 16-bit wrap
        in_valid = 1'b1;
        flush    = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_data = DW'(i);
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("wrap_last_data", a_dat, seq_row(64'd65534, 1));
        chk("wrap_pre_cnt", beat_cnt, 16'hFFFF);
        tick();
        chk("wrap_cnt_zero", beat_cnt, 0);
        chk("wrap_valid_drop", a_vld, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
